// File: rtl/fll_ctl_pkg.sv
// Shared types and width helpers for the FLL sequencing controller.
package fll_ctl_pkg;

    // Controller sequencing states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HOLD = 3'd1,
        ACQ  = 3'd2,
        LOCK = 3'd3,
        FAIL = 3'd4
    } fll_ctl_state_t;

    // Bits needed to hold a counter value in the range 0..max_v.
    function automatic int cnt_w(input int max_v);
        return (max_v < 1) ? 1 : $clog2(max_v + 1);
    endfunction

endpackage

// File: rtl/fll_ctl_win.sv
// Measurement window: counts reference and output increments, flags the
// window-closing cycle and whether the output count was within tolerance.
module fll_ctl_win
    import fll_ctl_pkg::*;
#(
    parameter int WIN = 16,
    parameter int TOL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic ref_evt,
    input  logic out_evt,
    output logic win_done,
    output logic win_good
);

    localparam int WC_W = cnt_w(WIN);
    localparam int OC_W = cnt_w(2 * WIN);
    localparam int LO_V = (WIN > TOL) ? (WIN - TOL) : 0;
    localparam int HI_V = ((WIN + TOL) < (2 * WIN)) ? (WIN + TOL) : (2 * WIN);

    localparam logic [WC_W-1:0] WC_LAST = WC_W'(WIN - 1);
    localparam logic [OC_W-1:0] OC_MAX  = OC_W'(2 * WIN);
    localparam logic [OC_W-1:0] OC_LO   = OC_W'(LO_V);
    localparam logic [OC_W-1:0] OC_HI   = OC_W'(HI_V);

    logic [WC_W-1:0] wc;
    logic [OC_W-1:0] oc;
    logic [OC_W-1:0] oc_eff;

    // Output count including this cycle's event, saturating at 2*WIN; an
    // output event in the closing cycle belongs to the closing window.
    always_comb begin
        oc_eff = oc;
        if (oc != OC_MAX) begin
            oc_eff = oc + OC_W'(out_evt);
        end
    end

    assign win_done = !clear && ref_evt && (wc == WC_LAST);
    assign win_good = win_done && (oc_eff >= OC_LO) && (oc_eff <= OC_HI);

    // Window counters; restart from zero after a close or while cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wc <= '0;
            oc <= '0;
        end else if (clear || win_done) begin
            wc <= '0;
            oc <= '0;
        end else begin
            wc <= wc + WC_W'(ref_evt);
            oc <= oc_eff;
        end
    end

endmodule

// File: rtl/fll_ctl.sv
// FLL sequencing controller: request handshake, FLL reset hold, lock
// acquisition with timeout, and lock supervision.
// Handshake: a request transfers on any clk_i edge where req_vld_i and
// req_rdy_o are both high; the requester holds valid and data stable until
// then, and ready never depends on valid.
module fll_ctl
    import fll_ctl_pkg::*;
#(
    parameter int CCW_I   = 8,
    parameter int CCW_O   = 8,
    parameter int RST_CYC = 4,
    parameter int WIN     = 16,
    parameter int TOL     = 1,
    parameter int GOOD    = 4,
    parameter int TMO     = 4096
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic [CCW_I-1:0] req_num_i_i,
    input  logic [CCW_O-1:0] req_num_o_i,
    output logic             fll_rst_o,
    output logic [CCW_I-1:0] fll_num_i_o,
    output logic [CCW_O-1:0] fll_num_o_o,
    input  logic             ref_evt_i,
    input  logic             out_evt_i,
    output logic             lock_o,
    output logic             lost_o,
    output logic             err_o,
    output fll_ctl_state_t   dbg_state
);

    localparam int HC_W = cnt_w(RST_CYC);
    localparam int TC_W = cnt_w(TMO);
    localparam int GC_W = cnt_w(GOOD);

    fll_ctl_state_t   state, state_d;
    logic             fll_rst_d, lock_d, lost_d, err_d;
    logic [CCW_I-1:0] num_i_d;
    logic [CCW_O-1:0] num_o_d;
    logic [HC_W-1:0]  hc, hc_d;
    logic [TC_W-1:0]  tc, tc_d;
    logic [GC_W-1:0]  gcnt, gcnt_d, gcnt_inc;
    logic             accept, measuring, win_done, win_good;

    assign req_rdy_o = (state == IDLE) || (state == LOCK) || (state == FAIL);
    assign accept    = req_vld_i && req_rdy_o;
    assign measuring = (state == ACQ) || (state == LOCK);
    assign dbg_state = state;

    fll_ctl_win #(
        .WIN (WIN),
        .TOL (TOL)
    ) u_win (
        .clk      (clk_i),
        .rst_n    (rst_ni),
        .clear    (!measuring || accept),
        .ref_evt  (ref_evt_i),
        .out_evt  (out_evt_i),
        .win_done (win_done),
        .win_good (win_good)
    );

    // Next-state and registered-output logic; an accepted request overrides
    // everything else, including a coincident bad window in LOCK.
    always_comb begin
        state_d  = state;
        num_i_d  = fll_num_i_o;
        num_o_d  = fll_num_o_o;
        lock_d   = lock_o;
        lost_d   = 1'b0;
        err_d    = err_o;
        hc_d     = hc;
        tc_d     = tc;
        gcnt_d   = gcnt;
        gcnt_inc = gcnt + GC_W'(1);
        if (accept) begin
            state_d = HOLD;
            num_i_d = req_num_i_i;
            num_o_d = req_num_o_i;
            lock_d  = 1'b0;
            err_d   = 1'b0;
            hc_d    = '0;
            tc_d    = '0;
            gcnt_d  = '0;
        end else begin
            case (state)
                HOLD: begin
                    if (hc == HC_W'(RST_CYC - 1)) begin
                        state_d = ACQ;
                        hc_d    = '0;
                    end else begin
                        hc_d = hc + HC_W'(1);
                    end
                end
                ACQ: begin
                    tc_d = tc + TC_W'(1);
                    if (win_done) begin
                        gcnt_d = win_good ? gcnt_inc : '0;
                    end
                    // Lock takes priority over a coincident timeout.
                    if (win_done && win_good && (gcnt_inc == GC_W'(GOOD))) begin
                        state_d = LOCK;
                        lock_d  = 1'b1;
                        tc_d    = '0;
                    end else if (tc == TC_W'(TMO - 1)) begin
                        state_d = FAIL;
                        err_d   = 1'b1;
                    end
                end
                LOCK: begin
                    if (win_done && !win_good) begin
                        state_d = ACQ;
                        lock_d  = 1'b0;
                        lost_d  = 1'b1;
                        tc_d    = '0;
                        gcnt_d  = '0;
                    end
                end
                default: begin
                end
            endcase
        end
        fll_rst_d = (state_d == IDLE) || (state_d == HOLD);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            fll_rst_o   <= 1'b1;
            fll_num_i_o <= '0;
            fll_num_o_o <= '0;
            lock_o      <= 1'b0;
            lost_o      <= 1'b0;
            err_o       <= 1'b0;
            hc          <= '0;
            tc          <= '0;
            gcnt        <= '0;
        end else begin
            state       <= state_d;
            fll_rst_o   <= fll_rst_d;
            fll_num_i_o <= num_i_d;
            fll_num_o_o <= num_o_d;
            lock_o      <= lock_d;
            lost_o      <= lost_d;
            err_o       <= err_d;
            hc          <= hc_d;
            tc          <= tc_d;
            gcnt        <= gcnt_d;
        end
    end

endmodule

// File: tb/tb_fll_ctl.sv
// Directed bench for fll_ctl with hand-computed expectations.
module tb_fll_ctl;
    import fll_ctl_pkg::*;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           req_vld;
    logic           req_rdy;
    logic [7:0]     req_num_i;
    logic [7:0]     req_num_o;
    logic           fll_rst;
    logic [7:0]     fll_num_i;
    logic [7:0]     fll_num_o;
    logic           ref_evt;
    logic           out_evt;
    logic           lock;
    logic           lost;
    logic           err;
    fll_ctl_state_t dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    fll_ctl dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .req_vld_i   (req_vld),
        .req_rdy_o   (req_rdy),
        .req_num_i_i (req_num_i),
        .req_num_o_i (req_num_o),
        .fll_rst_o   (fll_rst),
        .fll_num_i_o (fll_num_i),
        .fll_num_o_o (fll_num_o),
        .ref_evt_i   (ref_evt),
        .out_evt_i   (out_evt),
        .lock_o      (lock),
        .lost_o      (lost),
        .err_o       (err),
        .dbg_state   (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, wait (bounded) for ready, complete the transfer.
    task automatic send_req(input logic [7:0] ni, input logic [7:0] no);
        int w = 0;
        req_vld   = 1'b1;
        req_num_i = ni;
        req_num_o = no;
        while (!req_rdy && w < 200) begin
            tick();
            w++;
        end
        check("req_ready_in_time", 32'(req_rdy), 32'd1);
        tick();
        req_vld = 1'b0;
    endtask

    // Count samples with fll_rst high (bounded), ending on the first low one.
    task automatic hold_len(output int cnt);
        cnt = 0;
        while (fll_rst && cnt < 20) begin
            cnt++;
            tick();
        end
    endtask

    // One 16-reference-event window in 32 cycles: ref on odd cycles, the last
    // (cycle 31) closes the window. out on the first n_head cycles, plus on
    // the closing cycle when close_out is set. Returns one cycle after close.
    task automatic run_win(input int n_head, input bit close_out);
        for (int i = 0; i < 32; i++) begin
            ref_evt = (i % 2) == 1;
            out_evt = (i < n_head) || (close_out && i == 31);
            tick();
        end
        ref_evt = 1'b0;
        out_evt = 1'b0;
    endtask

    initial begin
        int cnt;
        rst_n     = 1'b0;
        req_vld   = 1'b0;
        req_num_i = '0;
        req_num_o = '0;
        ref_evt   = 1'b0;
        out_evt   = 1'b0;
        repeat (2) tick();

        // reset values
        check("rst_rdy", 32'(req_rdy), 32'd1);
        check("rst_fll_rst", 32'(fll_rst), 32'd1);
        check("rst_num_i", 32'(fll_num_i), 32'd0);
        check("rst_num_o", 32'(fll_num_o), 32'd0);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_lost", 32'(lost), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        tick();
        check("idle_stays", 32'(dbg_state), 32'(IDLE));

        // first request 9/4: HOLD 4 cycles with FLL reset, then ACQ
        send_req(8'd9, 8'd4);
        check("hold_state", 32'(dbg_state), 32'(HOLD));
        check("hold_rdy", 32'(req_rdy), 32'd0);
        check("hold_num_i", 32'(fll_num_i), 32'd9);
        check("hold_num_o", 32'(fll_num_o), 32'd4);
        hold_len(cnt);
        check("hold_len", 32'(cnt), 32'd4);
        check("acq_state", 32'(dbg_state), 32'(ACQ));
        check("acq_rdy", 32'(req_rdy), 32'd0);
        check("acq_fll_rst", 32'(fll_rst), 32'd0);

        // tolerance: 15/17/16 good, 18 bad clears the run
        run_win(15, 0); check("w15_lock", 32'(lock), 32'd0);
        run_win(17, 0); check("w17_lock", 32'(lock), 32'd0);
        run_win(16, 0); check("w16_lock", 32'(lock), 32'd0);
        run_win(18, 0); check("w18_lock", 32'(lock), 32'd0);
        // 16,16 good then 14 bad clears the run
        run_win(16, 0); check("w16b_lock", 32'(lock), 32'd0);
        run_win(16, 0); check("w16c_lock", 32'(lock), 32'd0);
        run_win(14, 0); check("w14_lock", 32'(lock), 32'd0);
        // 17 + closing-cycle output = 18: bad
        run_win(17, 1); check("w17c_lock", 32'(lock), 32'd0);
        run_win(15, 0); check("g1_lock", 32'(lock), 32'd0);
        run_win(17, 0); check("g2_lock", 32'(lock), 32'd0);
        run_win(16, 0); check("g3_lock", 32'(lock), 32'd0);
        // 14 + closing-cycle output = 15: good, fourth in a row -> lock
        run_win(14, 1);
        check("g4_lock", 32'(lock), 32'd1);
        check("g4_state", 32'(dbg_state), 32'(LOCK));
        check("g4_rdy", 32'(req_rdy), 32'd1);
        check("g4_lost", 32'(lost), 32'd0);

        // good window in LOCK keeps lock
        run_win(15, 0);
        check("lock_keep", 32'(lock), 32'd1);
        check("lock_keep_lost", 32'(lost), 32'd0);

        // oc=12 in LOCK: loss of lock
        run_win(12, 0);
        check("lost_pulse", 32'(lost), 32'd1);
        check("lost_lock", 32'(lock), 32'd0);
        check("lost_state", 32'(dbg_state), 32'(ACQ));
        tick();
        check("lost_single", 32'(lost), 32'd0);

        // relock after 4 good windows
        run_win(16, 0);
        run_win(16, 0);
        run_win(16, 0);
        check("relock3", 32'(lock), 32'd0);
        run_win(16, 0);
        check("relock4", 32'(lock), 32'd1);

        // drop to ACQ, then hold a request valid across acquisition
        run_win(12, 0);
        check("lost2_pulse", 32'(lost), 32'd1);
        req_vld   = 1'b1;
        req_num_i = 8'h5A;
        req_num_o = 8'hC3;
        run_win(16, 0);
        run_win(16, 0);
        run_win(16, 0);
        check("stall_rdy", 32'(req_rdy), 32'd0);
        check("stall_num_i", 32'(fll_num_i), 32'd9);
        run_win(16, 0);
        check("stall_lock", 32'(lock), 32'd1);
        check("stall_rdy_lock", 32'(req_rdy), 32'd1);
        tick();
        req_vld = 1'b0;
        check("acc_lock_state", 32'(dbg_state), 32'(HOLD));
        check("acc_lock_lock", 32'(lock), 32'd0);
        check("acc_lock_lost", 32'(lost), 32'd0);
        check("acc_lock_num_i", 32'(fll_num_i), 32'h5A);
        check("acc_lock_num_o", 32'(fll_num_o), 32'hC3);
        check("acc_lock_rst", 32'(fll_rst), 32'd1);
        hold_len(cnt);
        check("hold2_len", 32'(cnt), 32'd4);

        // no output events: timeout after 4096 ACQ cycles
        cnt = 0;
        while (dbg_state == ACQ && cnt < 5000) begin
            cnt++;
            tick();
        end
        check("tmo_cycles", 32'(cnt), 32'd4096);
        check("tmo_err", 32'(err), 32'd1);
        check("tmo_state", 32'(dbg_state), 32'(FAIL));
        check("tmo_fll_rst", 32'(fll_rst), 32'd0);
        check("tmo_rdy", 32'(req_rdy), 32'd1);
        repeat (10) tick();
        check("tmo_err_sticky", 32'(err), 32'd1);

        // new request clears err and restarts HOLD
        send_req(8'd3, 8'd7);
        check("fail_acc_err", 32'(err), 32'd0);
        check("fail_acc_state", 32'(dbg_state), 32'(HOLD));
        check("fail_acc_rst", 32'(fll_rst), 32'd1);
        check("fail_acc_num_i", 32'(fll_num_i), 32'd3);
        tick();

        // asynchronous reset mid-HOLD
        rst_n = 1'b0;
        #1;
        check("arst_state", 32'(dbg_state), 32'(IDLE));
        check("arst_num_i", 32'(fll_num_i), 32'd0);
        check("arst_num_o", 32'(fll_num_o), 32'd0);
        check("arst_rdy", 32'(req_rdy), 32'd1);
        check("arst_fll_rst", 32'(fll_rst), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_idle", 32'(dbg_state), 32'(IDLE));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
